// File: rtl/prog_bus_resp_pkg.sv
// prog_bus_resp_pkg
//   Shared definitions for the Tiny DSP program-bus responder: program bus
//   widths, responder state encodings and the out-of-range address helper.
//   Imported by prog_bus_resp and prog_bus_resp_ram.
package prog_bus_resp_pkg;

   // Program address is P_ADDR+1 bits wide, program data MSB+1 bits wide.
   localparam int P_ADDR = 15;
   localparam int MSB    = 15;

   // Responder FSM encodings.
   typedef enum logic [1:0] {
      RESP_IDLE = 2'd0,
      RESP_ADDR = 2'd1,
      RESP_BUSY = 2'd2
   } resp_state_e;

   // An address is out of range when any bit above the implemented RAM
   // index (bits [P_ADDR:aw]) is set.
   function automatic logic addr_oor(input logic [P_ADDR:0] addr, input int aw);
      return (addr >> aw) != {(P_ADDR + 1){1'b0}};
   endfunction

endpackage

// File: rtl/prog_bus_resp_ram.sv
// prog_bus_resp_ram
//   Synchronous single-port program RAM with a registered read port.
//   Ports:
//     clk_i     clock, rising edge
//     reset_i   synchronous active-high reset of the read register only
//     en_i      access enable
//     we_i      write enable (with en_i); a write leaves the read register alone
//     zero_i    on a read, load zero instead of the array word
//     addr_i    word index
//     wdata_i   write data
//     rdata_o   registered read data
module prog_bus_resp_ram
   import prog_bus_resp_pkg::*;
#(
   parameter int AW = 8,
   parameter int DW = MSB + 1
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          en_i,
   input  logic          we_i,
   input  logic          zero_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [0:(2**AW)-1];
   logic [DW-1:0] rdata_q;

   // Array write port; the array contents survive reset.
   always_ff @(posedge clk_i) begin
      if (en_i && we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   // Registered read port; holds its value on writes and idle cycles.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rdata_q <= {DW{1'b0}};
      end else if (en_i && !we_i) begin
         if (zero_i) begin
            rdata_q <= {DW{1'b0}};
         end else begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_bus_resp.sv
// prog_bus_resp
//   Memory-side end of the Tiny DSP program bus. Services master reads and
//   writes from an internal program RAM and flags protocol and address
//   violations.
//   Ports:
//     clk           clock, rising edge
//     reset         synchronous active-high reset
//     as            address strobe from the master
//     read          read enable
//     write         write enable (one-cycle pulse)
//     write_h       write hold
//     address       program address (P_ADDR+1 bits)
//     pad_data_out  write data from the master
//     pad_data_in   registered read data to the master
//     wr_strobe     one-cycle pulse in the cycle after a RAM write commits
//     prot_err      sticky protocol-violation flag
//     addr_err      sticky out-of-range access flag
module prog_bus_resp
   import prog_bus_resp_pkg::*;
#(
   parameter int AW      = 8,
   parameter int TIMEOUT = 7
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            as,
   input  logic            read,
   input  logic            write,
   input  logic            write_h,
   input  logic [P_ADDR:0] address,
   input  logic [MSB:0]    pad_data_out,
   output logic [MSB:0]    pad_data_in,
   output logic            wr_strobe,
   output logic            prot_err,
   output logic            addr_err
);

   localparam int            CW         = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TIMEOUT_C  = CW'(TIMEOUT);
   localparam logic [CW-1:0] TIMEOUT_M1 = CW'(TIMEOUT - 1);

   resp_state_e     state_q, state_d;
   logic [P_ADDR:0] addr_q, addr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            wr_strobe_q, wr_strobe_d;
   logic            prot_err_q, prot_err_d;
   logic            addr_err_q, addr_err_d;

   logic            oor_in_s;
   logic            oor_lat_s;
   logic            ram_en_s;
   logic            ram_we_s;
   logic [AW-1:0]   ram_addr_s;
   logic [MSB:0]    ram_rdata_s;

   assign oor_in_s  = addr_oor(address, AW);
   assign oor_lat_s = addr_oor(addr_q, AW);

   // Next-state, RAM control and error-flag logic for the responder FSM.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      wr_strobe_d = 1'b0;
      prot_err_d  = prot_err_q;
      addr_err_d  = addr_err_q;
      ram_en_s    = 1'b0;
      ram_we_s    = 1'b0;
      ram_addr_s  = addr_q[AW-1:0];

      case (state_q)
         RESP_IDLE: begin
            if (as) begin
               // Address phase: latch the address and prefetch straight from
               // the bus so data is on the pads one clock after as is seen.
               addr_d     = address;
               cnt_d      = {CW{1'b0}};
               ram_en_s   = 1'b1;
               ram_addr_s = address[AW-1:0];
               addr_err_d = addr_err_q | oor_in_s;
               state_d    = RESP_ADDR;
            end else begin
               state_d = RESP_IDLE;
            end
         end

         RESP_ADDR: begin
            if (as && read && !write) begin
               state_d = RESP_BUSY;
            end else if (as && write && write_h && !read) begin
               // Out-of-range writes are dropped silently apart from addr_err,
               // which was already raised in the address phase.
               ram_en_s    = !oor_lat_s;
               ram_we_s    = !oor_lat_s;
               wr_strobe_d = !oor_lat_s;
               state_d     = RESP_BUSY;
            end else begin
               prot_err_d = 1'b1;
               if (as) begin
                  state_d = RESP_BUSY;
               end else begin
                  state_d = RESP_IDLE;
               end
            end
         end

         RESP_BUSY: begin
            if (!as) begin
               state_d = RESP_IDLE;
            end else begin
               // write_h alone is the legal hold phase; anything else is not.
               if (read || write || (address != addr_q)) begin
                  prot_err_d = 1'b1;
               end else begin
                  prot_err_d = prot_err_q;
               end
               if (cnt_q == TIMEOUT_C) begin
                  cnt_d = cnt_q;
               end else begin
                  cnt_d = cnt_q + {{(CW - 1){1'b0}}, 1'b1};
               end
               // The increment taking place now reaches TIMEOUT: abandon the
               // transaction so a stuck master cannot hold the bus forever.
               if (cnt_q >= TIMEOUT_M1) begin
                  prot_err_d = 1'b1;
                  state_d    = RESP_IDLE;
               end else begin
                  state_d = RESP_BUSY;
               end
            end
         end

         default: begin
            state_d = RESP_IDLE;
         end
      endcase
   end

   // FSM state, latched address, timeout counter and registered flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RESP_IDLE;
         addr_q      <= {(P_ADDR + 1){1'b0}};
         cnt_q       <= {CW{1'b0}};
         wr_strobe_q <= 1'b0;
         prot_err_q  <= 1'b0;
         addr_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         wr_strobe_q <= wr_strobe_d;
         prot_err_q  <= prot_err_d;
         addr_err_q  <= addr_err_d;
      end
   end

   // Reset takes priority over a commit on the same edge so a write that
   // was in flight when reset hit is discarded.
   prog_bus_resp_ram #(
      .AW (AW),
      .DW (MSB + 1)
   ) u_prog_ram (
      .clk_i   (clk),
      .reset_i (reset),
      .en_i    (ram_en_s),
      .we_i    (ram_we_s & ~reset),
      .zero_i  (oor_in_s),
      .addr_i  (ram_addr_s),
      .wdata_i (pad_data_out),
      .rdata_o (ram_rdata_s)
   );

   assign pad_data_in = ram_rdata_s;
   assign wr_strobe   = wr_strobe_q;
   assign prot_err    = prot_err_q;
   assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_prog_bus_resp.sv
// tb_prog_bus_resp
//   Scoreboard bench for prog_bus_resp. A bus-master driver issues directed
//   and random program-bus transactions and pushes the expected responses
//   computed from a word-array model of the program store; a monitor pops
//   them whenever a write strobe, a master read capture or a status sample
//   occurs.
module tb_prog_bus_resp;
   import prog_bus_resp_pkg::*;

   localparam int AW   = 8;
   localparam int K_WR = 0;
   localparam int K_RD = 1;
   localparam int K_ST = 2;

   typedef struct {
      int           kind;
      logic [MSB:0] data;
      logic         prot;
      logic         aerr;
   } exp_t;

   logic            clk;
   logic            reset;
   logic            as;
   logic            read;
   logic            write;
   logic            write_h;
   logic [P_ADDR:0] address;
   logic [MSB:0]    pad_data_out;
   logic [MSB:0]    pad_data_in;
   logic            wr_strobe;
   logic            prot_err;
   logic            addr_err;

   exp_t            exp_q[$];
   logic [MSB:0]    mem_m [0:(2**AW)-1];
   logic [MSB:0]    pad_m;
   logic            prot_m;
   logic            aerr_m;
   logic            cap_rd = 1'b0;
   logic            cap_st = 1'b0;
   logic            done   = 1'b0;
   int              checks = 0;
   int              errors = 0;

   prog_bus_resp #(
      .AW      (AW),
      .TIMEOUT (7)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .as           (as),
      .read         (read),
      .write        (write),
      .write_h      (write_h),
      .address      (address),
      .pad_data_out (pad_data_out),
      .pad_data_in  (pad_data_in),
      .wr_strobe    (wr_strobe),
      .prot_err     (prot_err),
      .addr_err     (addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic is_oor(input logic [P_ADDR:0] a);
      return (a >> AW) != {(P_ADDR + 1){1'b0}};
   endfunction

   function automatic logic [MSB:0] model_rd(input logic [P_ADDR:0] a);
      logic [AW-1:0] idx;
      idx = a[AW-1:0];
      if (is_oor(a)) return {(MSB + 1){1'b0}};
      return mem_m[idx];
   endfunction

   task automatic push(input int kind, input logic [MSB:0] data);
      exp_t e;
      e.kind = kind;
      e.data = data;
      e.prot = prot_m;
      e.aerr = aerr_m;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic status();
      push(K_ST, pad_m);
      cap_st = 1'b1;
      tick();
      cap_st = 1'b0;
   endtask

   task automatic apply_reset();
      as = 1'b0; read = 1'b0; write = 1'b0; write_h = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      pad_m = '0; prot_m = 1'b0; aerr_m = 1'b0;
   endtask

   // Master read: as from E0, read sampled at E2, capture at E2.
   task automatic do_read(input logic [P_ADDR:0] a);
      pad_m = model_rd(a);
      if (is_oor(a)) aerr_m = 1'b1;
      push(K_RD, pad_m);
      as = 1'b1; address = a;
      tick();
      read = 1'b1;
      tick();
      read = 1'b0; as = 1'b0; cap_rd = 1'b1;
      tick();
      cap_rd = 1'b0;
   endtask

   // Master write: write sampled at E2, write_h at E2-E3, as low after E4.
   task automatic do_write(input logic [P_ADDR:0] a, input logic [MSB:0] d);
      logic [AW-1:0] idx;
      idx   = a[AW-1:0];
      pad_m = model_rd(a);
      if (is_oor(a)) begin
         aerr_m = 1'b1;
      end else begin
         mem_m[idx] = d;
         push(K_WR, d);
      end
      as = 1'b1; address = a; pad_data_out = d;
      tick();
      write = 1'b1; write_h = 1'b1;
      tick();
      write = 1'b0;
      tick();
      write_h = 1'b0;
      tick();
      as = 1'b0;
      tick();
   endtask

   // Illegal address phase: (rd, wr, wh) as given, then the master backs off.
   task automatic do_bad(input logic [P_ADDR:0] a, input logic rd, input logic wr, input logic wh);
      pad_m  = model_rd(a);
      prot_m = 1'b1;
      as = 1'b1; address = a; pad_data_out = 16'($urandom);
      tick();
      read = rd; write = wr; write_h = wh;
      tick();
      read = 1'b0; write = 1'b0; write_h = 1'b0; as = 1'b0;
      tick();
   endtask

   // Legal read whose master then keeps as high for 10 sampled cycles.
   task automatic do_timeout(input logic [P_ADDR:0] a);
      pad_m = model_rd(a);
      push(K_RD, pad_m);
      as = 1'b1; address = a;
      tick();
      read = 1'b1;
      tick();
      read = 1'b0; cap_rd = 1'b1;
      tick();
      cap_rd = 1'b0;
      repeat (5) tick();
      status();
      prot_m = 1'b1;
      status();
      as = 1'b0;
      tick();
      tick();
   endtask

   // Legal read, but the address moves while as is still high in BUSY.
   task automatic do_addr_change(input logic [P_ADDR:0] a);
      pad_m = model_rd(a);
      push(K_RD, pad_m);
      as = 1'b1; address = a;
      tick();
      read = 1'b1;
      tick();
      read = 1'b0; cap_rd = 1'b1; address = a ^ 16'h0001;
      tick();
      cap_rd = 1'b0; as = 1'b0;
      prot_m = 1'b1;
      tick();
   endtask

   // Reset sampled at E1 of a write; the master abandons the transfer.
   task automatic do_reset_midwrite(input logic [P_ADDR:0] a, input logic [MSB:0] d);
      as = 1'b1; address = a; pad_data_out = d; reset = 1'b1;
      tick();
      reset = 1'b0; as = 1'b0;
      pad_m = '0; prot_m = 1'b0; aerr_m = 1'b0;
      status();
      status();
   endtask

   task automatic chk_pop(input int kind);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_output: kind %0d seen at %0t, nothing expected", kind, $time);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind) begin
            errors++;
            $display("FAIL order: got kind %0d at %0t, expected kind %0d", kind, $time, e.kind);
         end else if (kind == K_RD && pad_data_in !== e.data) begin
            errors++;
            $display("FAIL read_data: pad_data_in=%h expected %h at %0t", pad_data_in, e.data, $time);
         end else if (kind == K_ST &&
                      (pad_data_in !== e.data || prot_err !== e.prot ||
                       addr_err !== e.aerr || wr_strobe !== 1'b0)) begin
            errors++;
            $display("FAIL status: pad_data_in=%h exp %h prot_err=%b exp %b addr_err=%b exp %b wr_strobe=%b exp 0 at %0t",
                     pad_data_in, e.data, prot_err, e.prot, addr_err, e.aerr, wr_strobe, $time);
         end
      end
   endtask

   // Monitor: compares DUT outputs against the scoreboard, then reports.
   initial begin
      while (!done) begin
         @(negedge clk);
         if (wr_strobe === 1'b1) chk_pop(K_WR);
         if (cap_rd) chk_pop(K_RD);
         if (cap_st) chk_pop(K_ST);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover: %0d expected responses never seen, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: still running at %0t, limit 1000000", $time);
      $fatal(1, "watchdog expired");
   end

   // Driver: directed scenarios, back-to-back traffic, then random traffic.
   initial begin
      logic [P_ADDR:0] a;
      logic [P_ADDR:0] last_a;
      reset = 1'b1; as = 1'b0; read = 1'b0; write = 1'b0; write_h = 1'b0;
      address = '0; pad_data_out = '0;
      tick();
      tick();
      reset = 1'b0;
      pad_m = '0; prot_m = 1'b0; aerr_m = 1'b0;
      status();

      // Give every RAM word a known value.
      for (int i = 0; i < 2**AW; i++) begin
         do_write(16'(i), 16'($urandom));
      end

      do_write(16'h0010, 16'hBEEF);
      do_read(16'h0010);
      status();

      do_write(16'h0020, 16'h1234);
      do_read(16'h0020);
      status();

      do_read(16'h0110);
      status();
      do_write(16'h0120, 16'hDEAD);
      status();
      apply_reset();
      do_read(16'h0020);
      status();

      do_bad(16'h0030, 1'b0, 1'b1, 1'b0);
      status();
      do_read(16'h0030);
      apply_reset();
      do_timeout(16'h0040);
      status();
      apply_reset();
      do_bad(16'h0050, 1'b1, 1'b1, 1'b1);
      status();
      do_read(16'h0050);
      apply_reset();
      do_addr_change(16'h0044);
      status();
      apply_reset();

      do_reset_midwrite(16'h0060, 16'hA5A5);
      do_read(16'h0060);
      status();
      do_write(16'h0060, 16'h5A5A);
      do_read(16'h0060);
      status();

      last_a = '0;
      for (int i = 0; i < 20; i++) begin
         if (i % 2 == 0) begin
            last_a = {8'h00, 8'($urandom)};
            do_write(last_a, 16'($urandom));
         end else begin
            do_read(last_a);
         end
      end
      status();

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 3))
            0: a = {8'h00, 8'($urandom)};
            1: a = {8'h00, 8'($urandom)};
            default: a = {8'($urandom_range(1, 255)), 8'($urandom)};
         endcase
         if ($urandom_range(0, 1) == 0) begin
            do_read(a);
         end else begin
            do_write(a, 16'($urandom));
         end
         status();
      end

      tick();
      tick();
      done = 1'b1;
   end

endmodule
